writeback_scoreboard: RTL and testbench

Drives the register-file write port from the MEM/WB boundary and tracks which architectural registers have in-flight writes, so decode can stall on read-after-write hazards. Sits between the memory stage, the register file write port (`wrEnable`, `wrReg`, `wrData`) and the decode stage's read addresses. The register file writes on the falling edge of `clk`; this block is rising-edge only.

---
 rtl/writeback_scoreboard.sv | 92 +++++++++
 tb/tb_writeback_scoreboard.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_scoreboard.sv
// MEM/WB write-back register plus per-register pending-write counters used by decode to stall
// on read-after-write hazards and to refuse issues once a register has too many writes in flight.
module writeback_scoreboard #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned MAX_INFLIGHT = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issueValid,
   input  logic [4:0]            issueReg,
   output logic                  issueStall,
   input  logic                  memValid,
   input  logic                  memRegWrite,
   input  logic                  memToReg,
   input  logic [4:0]            memReg,
   input  logic [DATA_WIDTH-1:0] aluResult,
   input  logic [DATA_WIDTH-1:0] memData,
   output logic                  wrEnable,
   output logic [4:0]            wrReg,
   output logic [DATA_WIDTH-1:0] wrData,
   input  logic [4:0]            rdReg1,
   input  logic [4:0]            rdReg2,
   input  logic                  use1,
   input  logic                  use2,
   output logic                  hazardStall
);

   localparam int unsigned CntW = (MAX_INFLIGHT < 2) ? 1 : $clog2(MAX_INFLIGHT + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(MAX_INFLIGHT);
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   logic                  wr_enable_q;
   logic [4:0]            wr_reg_q;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic [CntW-1:0]       cnt_q [32];
   logic [CntW-1:0]       cnt_d [32];
   logic [31:0]           busy;
   logic                  inc;
   logic                  dec;

   assign wrEnable = wr_enable_q;
   assign wrReg    = wr_reg_q;
   assign wrData   = wr_data_q;

   assign issueStall = issueValid & (issueReg != 5'd0) & (cnt_q[issueReg] == CntMax);

   // A write in its WB cycle no longer counts: the register file commits it on this negedge.
   always_comb begin
      busy = '0;
      for (int r = 1; r < 32; r++) begin
         busy[r] = (cnt_q[r] != '0) &&
                   !(wr_enable_q && (wr_reg_q == 5'(r)) && (cnt_q[r] == CntOne));
      end
   end

   assign hazardStall = (use1 & busy[rdReg1]) | (use2 & busy[rdReg2]);

   always_comb begin
      inc = 1'b0;
      dec = 1'b0;
      cnt_d[0] = '0;
      for (int r = 1; r < 32; r++) begin
         inc = issueValid & ~issueStall & (issueReg == 5'(r));
         dec = wr_enable_q & (wr_reg_q == 5'(r));
         cnt_d[r] = cnt_q[r];
         if (inc && !dec) begin
            cnt_d[r] = cnt_q[r] + CntOne;
         end else if (dec && !inc && (cnt_q[r] != '0)) begin
            cnt_d[r] = cnt_q[r] - CntOne;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_enable_q <= 1'b0;
         wr_reg_q    <= '0;
         wr_data_q   <= '0;
         for (int r = 0; r < 32; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         wr_enable_q <= memValid & memRegWrite & (memReg != 5'd0);
         wr_reg_q    <= memReg;
         wr_data_q   <= memToReg ? memData : aluResult;
         for (int r = 0; r < 32; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Directed bench for writeback_scoreboard with a negedge register-file model and an
// independent pending-count model that flags retirements to registers with nothing pending.
module tb_writeback_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        issueValid;
   logic [4:0]  issueReg;
   logic        issueStall;
   logic        memValid;
   logic        memRegWrite;
   logic        memToReg;
   logic [4:0]  memReg;
   logic [31:0] aluResult;
   logic [31:0] memData;
   logic        wrEnable;
   logic [4:0]  wrReg;
   logic [31:0] wrData;
   logic [4:0]  rdReg1;
   logic [4:0]  rdReg2;
   logic        use1;
   logic        use2;
   logic        hazardStall;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [31:0] rf [32];
   int          m_cnt [32];
   logic        m_wb_en = 1'b0;
   logic [4:0]  m_wb_reg = '0;

   writeback_scoreboard #(
      .DATA_WIDTH  (32),
      .MAX_INFLIGHT(3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .issueValid (issueValid),
      .issueReg   (issueReg),
      .issueStall (issueStall),
      .memValid   (memValid),
      .memRegWrite(memRegWrite),
      .memToReg   (memToReg),
      .memReg     (memReg),
      .aluResult  (aluResult),
      .memData    (memData),
      .wrEnable   (wrEnable),
      .wrReg      (wrReg),
      .wrData     (wrData),
      .rdReg1     (rdReg1),
      .rdReg2     (rdReg2),
      .use1       (use1),
      .use2       (use2),
      .hazardStall(hazardStall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wrEnable === 1'b1) rf[wrReg] <= wrData;
   end

   // Independent pending-count model; any retire against an empty count is a protocol error.
   always @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 32; r++) m_cnt[r] = 0;
         m_wb_en = 1'b0;
      end else begin
         if (m_wb_en) check("no_underflow", 32'(m_cnt[m_wb_reg] != 0), 32'd1);
         for (int r = 1; r < 32; r++) begin
            if (issueValid && issueReg == 5'(r) && m_cnt[r] != 3) m_cnt[r] = m_cnt[r] + 1;
            if (m_wb_en && m_wb_reg == 5'(r) && m_cnt[r] > 0) m_cnt[r] = m_cnt[r] - 1;
         end
         m_wb_en  = memValid & memRegWrite & (memReg != 5'd0);
         m_wb_reg = memReg;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mem(input logic [4:0] r, input logic to_reg, input logic [31:0] alu,
                          input logic [31:0] data);
      memValid    = 1'b1;
      memRegWrite = 1'b1;
      memToReg    = to_reg;
      memReg      = r;
      aluResult   = alu;
      memData     = data;
   endtask

   task automatic clear_mem();
      memValid    = 1'b0;
      memRegWrite = 1'b0;
      memToReg    = 1'b0;
      memReg      = '0;
      aluResult   = '0;
      memData     = '0;
   endtask

   initial begin
      for (int r = 0; r < 32; r++) rf[r] = '0;
      rst = 1'b1;
      issueValid = 1'b1;
      issueReg = 5'd5;
      clear_mem();
      rdReg1 = '0;
      rdReg2 = '0;
      use1 = 1'b0;
      use2 = 1'b0;

      // 1. Reset values, with an issue held during reset
      tick();
      tick();
      rst = 1'b0;
      issueValid = 1'b0;
      rdReg1 = 5'd5;
      use1 = 1'b1;
      #1;
      check("rst_wrEnable", 32'(wrEnable), 32'd0);
      check("rst_wrData", wrData, 32'd0);
      check("rst_hazard_r5", 32'(hazardStall), 32'd0);
      check("rst_issueStall", 32'(issueStall), 32'd0);

      // 2. Basic RAW on r8
      issueValid = 1'b1;
      issueReg = 5'd8;
      rdReg1 = 5'd8;
      #1;
      check("raw_pre_issue", 32'(hazardStall), 32'd0);
      tick();
      issueValid = 1'b0;
      #1;
      check("raw_idle1", 32'(hazardStall), 32'd1);
      tick();
      check("raw_idle2", 32'(hazardStall), 32'd1);
      tick();
      set_mem(5'd8, 1'b0, 32'h1234, 32'hFFFF_0000);
      #1;
      check("raw_mem_cycle", 32'(hazardStall), 32'd1);
      tick();
      clear_mem();
      #1;
      check("raw_wb_hazard", 32'(hazardStall), 32'd0);
      check("raw_wb_en", 32'(wrEnable), 32'd1);
      check("raw_wb_reg", 32'(wrReg), 32'd8);
      check("raw_wb_data", wrData, 32'h1234);
      @(negedge clk);
      #1;
      check("raw_rf_r8", rf[8], 32'h1234);
      tick();
      check("raw_after_hazard", 32'(hazardStall), 32'd0);
      check("raw_after_en", 32'(wrEnable), 32'd0);

      // 3. Load select, r0 write suppression, r0 issue never stalls
      issueValid = 1'b1;
      issueReg = 5'd3;
      tick();
      issueValid = 1'b0;
      set_mem(5'd3, 1'b1, 32'h5555_5555, 32'hDEAD_BEEF);
      tick();
      clear_mem();
      #1;
      check("load_en", 32'(wrEnable), 32'd1);
      check("load_data", wrData, 32'hDEAD_BEEF);
      tick();
      set_mem(5'd0, 1'b1, 32'h5555_5555, 32'hDEAD_BEEF);
      tick();
      clear_mem();
      rdReg1 = 5'd3;
      #1;
      check("r0_wrEnable", 32'(wrEnable), 32'd0);
      check("r0_r3_not_busy", 32'(hazardStall), 32'd0);
      issueValid = 1'b1;
      issueReg = 5'd0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("r0_issue_stall", 32'(issueStall), 32'd0);
         tick();
      end
      issueValid = 1'b0;
      rdReg1 = 5'd0;
      #1;
      check("r0_never_busy", 32'(hazardStall), 32'd0);

      // 4. Saturation on r9
      issueValid = 1'b1;
      issueReg = 5'd9;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("sat_accept", 32'(issueStall), 32'd0);
         tick();
      end
      check("sat_fourth_refused", 32'(issueStall), 32'd1);
      tick();
      check("sat_still_refused", 32'(issueStall), 32'd1);
      issueValid = 1'b0;
      set_mem(5'd9, 1'b0, 32'h9, 32'h0);
      tick();
      clear_mem();
      tick();
      issueValid = 1'b1;
      #1;
      check("sat_after_retire", 32'(issueStall), 32'd0);
      tick();
      check("sat_full_again", 32'(issueStall), 32'd1);
      issueValid = 1'b0;
      rdReg1 = 5'd9;
      set_mem(5'd9, 1'b0, 32'h9, 32'h0);
      tick();
      tick();
      check("b2b_busy_cnt2", 32'(hazardStall), 32'd1);
      tick();
      clear_mem();
      #1;
      check("b2b_last_wb", 32'(hazardStall), 32'd0);
      tick();
      check("b2b_drained", 32'(hazardStall), 32'd0);

      // 5. Simultaneous issue and retire on r4
      issueValid = 1'b1;
      issueReg = 5'd4;
      rdReg1 = 5'd4;
      tick();
      issueValid = 1'b0;
      set_mem(5'd4, 1'b0, 32'h4, 32'h0);
      tick();
      clear_mem();
      issueValid = 1'b1;
      tick();
      issueValid = 1'b0;
      #1;
      check("same_cycle_busy", 32'(hazardStall), 32'd1);
      tick();
      check("same_cycle_hold", 32'(hazardStall), 32'd1);
      set_mem(5'd4, 1'b0, 32'h4, 32'h0);
      tick();
      clear_mem();
      tick();
      check("same_cycle_drained", 32'(hazardStall), 32'd0);

      // 6. Reset mid-operation: r2, r7 pending, r5 write held in WB
      for (int i = 0; i < 3; i++) begin
         issueValid = 1'b1;
         issueReg = (i == 0) ? 5'd2 : ((i == 1) ? 5'd7 : 5'd5);
         tick();
      end
      issueValid = 1'b0;
      set_mem(5'd5, 1'b0, 32'h5, 32'h0);
      tick();
      clear_mem();
      rdReg1 = 5'd2;
      rdReg2 = 5'd7;
      use2 = 1'b1;
      #1;
      check("mid_pre_busy", 32'(hazardStall), 32'd1);
      rst = 1'b1;
      set_mem(5'd2, 1'b0, 32'hBAD, 32'h0);
      tick();
      rst = 1'b0;
      clear_mem();
      #1;
      check("mid_rst_wrEnable", 32'(wrEnable), 32'd0);
      check("mid_rst_hazard", 32'(hazardStall), 32'd0);
      @(negedge clk);
      #1;
      check("mid_rf_r2", rf[2], 32'd0);
      check("mid_rf_r7", rf[7], 32'd0);
      tick();
      check("mid_next_wrEnable", 32'(wrEnable), 32'd0);
      check("mid_next_hazard", 32'(hazardStall), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
